// File: rtl/cdc_in_packetizer.sv
// rtl/cdc_in_packetizer.sv - packs CDC transmit FIFO bytes into bulk-IN packets with timeout, flush and ZLP
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   fifo_rdata          FIFO head byte (first-word-fall-through), valid while fifo_rempty=0
//   fifo_rempty         FIFO empty
//   fifo_rinc           pop strobe, combinational
//   flush               level request to close the current packet once the output byte has drained
//   ep_data, ep_valid   registered endpoint byte; transfers on ep_valid && ep_ready
//   ep_ready            endpoint accepts a byte or a packet finish
//   ep_pktfin           packet finish; completes on ep_pktfin && ep_ready
//   ep_pktlen           byte count of the packet being finished (0 = zero-length packet)
//   pkt_count           completed finishes including ZLPs, wrapping
//   busy                state machine is not idle

module cdc_in_packetizer #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_PKT        = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          fifo_rdata,
    input  logic                           fifo_rempty,
    output logic                           fifo_rinc,
    input  logic                           flush,
    output logic [DATA_WIDTH-1:0]          ep_data,
    output logic                           ep_valid,
    input  logic                           ep_ready,
    output logic                           ep_pktfin,
    output logic [$clog2(MAX_PKT+1)-1:0]   ep_pktlen,
    output logic [15:0]                    pkt_count,
    output logic                           busy
);

    localparam int LW = $clog2(MAX_PKT + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES);
    localparam logic [LW-1:0] MAX_CNT   = LW'(MAX_PKT);
    localparam logic [IW-1:0] IDLE_TERM = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_FIN,
        S_ZWAIT,
        S_ZFIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [LW-1:0]   load_cnt;
    logic [IW-1:0]   idle_cnt;
    logic            zlp_pend;
    logic            pop;
    logic            send_close;
    logic            out_free;
    logic            idle_term;
    logic            short_timeout;

    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        send_close    = 1'b0;
        ep_pktfin     = 1'b0;
        ep_pktlen     = '0;
        out_free      = !ep_valid || ep_ready;
        idle_term     = (idle_cnt == IDLE_TERM);
        short_timeout = (load_cnt != '0) && idle_term;

        case (state)
            S_IDLE: begin
                if (!fifo_rempty) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                // A timed-out short packet closes before taking another byte, so a
                // byte arriving on the terminal count begins the next packet.
                pop = !fifo_rempty && out_free && (load_cnt < MAX_CNT) && !short_timeout;
                if (!pop && out_free &&
                    ((load_cnt == MAX_CNT) || ((load_cnt != '0) && (idle_term || flush)))) begin
                    send_close = 1'b1;
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                ep_pktfin = 1'b1;
                ep_pktlen = load_cnt;
                if (ep_ready) begin
                    state_next = zlp_pend ? S_ZWAIT : S_IDLE;
                end
            end
            S_ZWAIT: begin
                if (!fifo_rempty) begin
                    state_next = S_SEND;
                end else if (idle_term || flush) begin
                    state_next = S_ZFIN;
                end
            end
            S_ZFIN: begin
                ep_pktfin = 1'b1;
                if (ep_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign fifo_rinc = pop;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            load_cnt  <= '0;
            idle_cnt  <= '0;
            zlp_pend  <= 1'b0;
            ep_data   <= '0;
            ep_valid  <= 1'b0;
            pkt_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    load_cnt <= '0;
                    idle_cnt <= '0;
                end
                S_SEND: begin
                    if (pop) begin
                        ep_data  <= fifo_rdata;
                        ep_valid <= 1'b1;
                        load_cnt <= load_cnt + LW'(1);
                        idle_cnt <= '0;
                    end else begin
                        if (ep_ready) begin
                            ep_valid <= 1'b0;
                        end
                        if (fifo_rempty && !idle_term) begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                    if (send_close) begin
                        // Only a full-length packet needs a ZLP to mark its end.
                        zlp_pend <= (load_cnt == MAX_CNT);
                    end
                end
                S_FIN: begin
                    if (ep_ready) begin
                        pkt_count <= pkt_count + 16'd1;
                        load_cnt  <= '0;
                        idle_cnt  <= '0;
                    end
                end
                S_ZWAIT: begin
                    if (!fifo_rempty) begin
                        zlp_pend <= 1'b0;
                        idle_cnt <= '0;
                    end else if (!idle_term) begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                S_ZFIN: begin
                    if (ep_ready) begin
                        pkt_count <= pkt_count + 16'd1;
                        zlp_pend  <= 1'b0;
                    end
                end
                default: begin
                    load_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_in_packetizer.sv
// tb/tb_cdc_in_packetizer.sv - directed self-checking bench for cdc_in_packetizer

module tb_cdc_in_packetizer;

    localparam int DW = 8;
    localparam int MP = 4;
    localparam int TO = 8;
    localparam int LW = $clog2(MP + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rempty;
    logic          fifo_rinc;
    logic          flush;
    logic [DW-1:0] ep_data;
    logic          ep_valid;
    logic          ep_ready;
    logic          ep_pktfin;
    logic [LW-1:0] ep_pktlen;
    logic [15:0]   pkt_count;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cdc_in_packetizer #(
        .DATA_WIDTH    (DW),
        .MAX_PKT       (MP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_rdata (fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .fifo_rinc  (fifo_rinc),
        .flush      (flush),
        .ep_data    (ep_data),
        .ep_valid   (ep_valid),
        .ep_ready   (ep_ready),
        .ep_pktfin  (ep_pktfin),
        .ep_pktlen  (ep_pktlen),
        .pkt_count  (pkt_count),
        .busy       (busy)
    );

    // first-word-fall-through FIFO model; contents are discarded on reset
    logic [7:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_rempty = (rd_ptr == wr_ptr);
    assign fifo_rdata  = fmem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (!rst_n) rd_ptr <= wr_ptr;
        else if (fifo_rinc) rd_ptr <= rd_ptr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // monitor: records transfers and finishes with their cycle numbers
    int         cyc = 0;
    logic [7:0] beats[$];
    int         beat_cyc[$];
    int         fin_len[$];
    int         fin_cyc[$];
    int         vio = 0;
    logic       fin_stall = 1'b0;
    logic [LW-1:0] stall_len = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ep_valid && ep_ready) begin
                beats.push_back(ep_data);
                beat_cyc.push_back(cyc);
            end
            if (ep_pktfin && ep_ready) begin
                fin_len.push_back(int'(ep_pktlen));
                fin_cyc.push_back(cyc);
            end
            vio <= vio + ((fifo_rinc && (fifo_rempty || (ep_valid && !ep_ready))) ? 1 : 0)
                       + ((ep_pktfin && ep_valid) ? 1 : 0);
            if (fin_stall) check("fin_held", {ep_pktfin, ep_pktlen}, {1'b1, stall_len});
            fin_stall <= ep_pktfin && !ep_ready;
            stall_len <= ep_pktlen;
        end else begin
            fin_stall <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    int bb;
    int fb;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] beat_at(input int i);
        return (i < beats.size()) ? beats[i] : 8'hxx;
    endfunction
    function automatic int beat_c(input int i);
        return (i < beat_cyc.size()) ? beat_cyc[i] : -1000;
    endfunction
    function automatic int fin_at(input int i);
        return (i < fin_len.size()) ? fin_len[i] : -1;
    endfunction
    function automatic int fin_c(input int i);
        return (i < fin_cyc.size()) ? fin_cyc[i] : -1000;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic mark();
        bb = beats.size();
        fb = fin_len.size();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_count"}, beats.size() - bb, exp_q.size());
        foreach (exp_q[i]) check($sformatf("%s_b%0d", tag, i), beat_at(bb + i), exp_q[i]);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ep_data"},   ep_data,   0);
        check({tag, "_ep_valid"},  ep_valid,  0);
        check({tag, "_ep_pktfin"}, ep_pktfin, 0);
        check({tag, "_ep_pktlen"}, ep_pktlen, 0);
        check({tag, "_pkt_count"}, pkt_count, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_fifo_rinc"}, fifo_rinc, 0);
    endtask

    int pc;
    int k;
    int gap;

    initial begin
        rst_n    = 1'b0;
        ep_ready = 1'b1;
        flush    = 1'b0;
        tick(3);
        check_zero_outputs("rst");
        rst_n = 1'b1;
        tick(1);

        // 1: short packet closed by timeout
        mark();
        push(8'h11); push(8'h22); push(8'h33);
        exp_q = '{8'h11, 8'h22, 8'h33};
        pc = cyc;
        tick(20);
        check_beats("t1");
        check("t1_latency", beat_c(bb) - pc, 2);
        check("t1_nfin", fin_len.size() - fb, 1);
        check("t1_len", fin_at(fb), 3);
        check("t1_idle_gap", fin_c(fb) - beat_c(bb + 2) - 1, TO - 1);
        check("t1_pkt_count", pkt_count, 1);
        check("t1_busy", busy, 0);

        // 2: full packet followed by ZLP
        do_reset();
        mark();
        for (int i = 0; i < 4; i++) begin
            push(8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
        end
        tick(25);
        check_beats("t2");
        check("t2_nfin", fin_len.size() - fb, 2);
        check("t2_len_full", fin_at(fb), 4);
        check("t2_len_zlp", fin_at(fb + 1), 0);
        check("t2_fin_latency", fin_c(fb) - beat_c(bb + 3), 1);
        gap = fin_c(fb + 1) - fin_c(fb) - 1;
        check("t2_zwait_gap", (gap >= TO - 1) && (gap <= TO), 1);
        check("t2_pkt_count", pkt_count, 2);

        // 3: data arriving in ZWAIT suppresses the ZLP
        do_reset();
        mark();
        for (int i = 0; i < 6; i++) begin
            push(8'(i));
            exp_q.push_back(8'(i));
        end
        tick(30);
        check_beats("t3");
        check("t3_nfin", fin_len.size() - fb, 2);
        check("t3_len0", fin_at(fb), 4);
        check("t3_len1", fin_at(fb + 1), 2);
        check("t3_pkt_count", pkt_count, 2);

        // 4: ep_ready toggling every cycle
        do_reset();
        mark();
        for (int i = 0; i < 4; i++) begin
            push(8'hB0 + 8'(i));
            exp_q.push_back(8'hB0 + 8'(i));
        end
        pc = vio;
        for (int i = 0; i < 40; i++) begin
            ep_ready = (i % 2 == 0);
            tick(1);
        end
        ep_ready = 1'b1;
        tick(2);
        check_beats("t4");
        check("t4_len_full", fin_at(fb), 4);
        check("t4_len_zlp", fin_at(fb + 1), 0);
        check("t4_protocol_vio", vio - pc, 0);
        check("t4_pkt_count", pkt_count, 2);

        // 5: flush closes a short packet without waiting for the timeout
        do_reset();
        mark();
        push(8'hC1); push(8'hC2);
        exp_q = '{8'hC1, 8'hC2};
        k = 0;
        while (k < 20 && beats.size() < bb + 2) begin
            tick(1);
            k++;
        end
        check("t5_second_beat_seen", beats.size() >= bb + 2, 1);
        flush = 1'b1;
        pc = cyc;
        tick(1);
        flush = 1'b0;
        tick(5);
        check_beats("t5");
        check("t5_nfin", fin_len.size() - fb, 1);
        check("t5_len", fin_at(fb), 2);
        check("t5_flush_latency", fin_c(fb) - pc, 1);
        fb = fin_len.size();
        flush = 1'b1;
        tick(3);
        flush = 1'b0;
        tick(2);
        check("t5_idle_flush_nofin", fin_len.size() - fb, 0);
        check("t5_idle_busy", busy, 0);
        check("t5_pkt_count", pkt_count, 1);

        // 6: reset mid-packet discards the partial packet
        do_reset();
        mark();
        push(8'h61); push(8'h62); push(8'h63);
        k = 0;
        while (k < 20 && !(ep_valid && ep_data == 8'h62)) begin
            tick(1);
            k++;
        end
        check("t6_second_byte_seen", ep_valid && (ep_data == 8'h62), 1);
        #1 rst_n = 1'b0;
        #1 check_zero_outputs("t6_rst");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        push(8'h77); push(8'h88);
        exp_q = '{8'h61, 8'h77, 8'h88};
        tick(20);
        check_beats("t6");
        check("t6_nfin", fin_len.size() - fb, 1);
        check("t6_len", fin_at(fb), 2);
        check("t6_pkt_count", pkt_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
